// File: rtl/vproc_div_block_pkg.sv
// Shared defaults and helpers for the vector divide block.
package vproc_div_block_pkg;

  localparam int unsigned DIV_ELEM_W_DEF         = 16;
  localparam int unsigned DIV_BITS_PER_CYCLE_DEF = 1;
  localparam int unsigned DIV_TAG_W_DEF          = 4;

  // Number of restoring steps needed for one element.
  function automatic int unsigned div_steps(input int unsigned elem_w, input int unsigned bpc);
    return elem_w / bpc;
  endfunction

endpackage

// File: rtl/vproc_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module vproc_div_step #(
  parameter int unsigned ELEM_W = 16
) (
  input  logic [ELEM_W:0] rem_i,
  input  logic            dvd_bit_i,
  input  logic [ELEM_W:0] divisor_i,
  output logic [ELEM_W:0] rem_o,
  output logic            quot_bit_o
);

  logic [ELEM_W+1:0] shifted;
  logic [ELEM_W+1:0] diff;

  // The partial remainder is always below the divisor, so the top shifted bit is zero.
  assign shifted    = {rem_i, dvd_bit_i};
  assign diff       = shifted - {1'b0, divisor_i};
  assign quot_bit_o = ~diff[ELEM_W+1];
  assign rem_o      = quot_bit_o ? diff[ELEM_W:0] : shifted[ELEM_W:0];

endmodule

// File: rtl/vproc_div_block.sv
// Iterative restoring divider (RISC-V M/V semantics), valid/ready in and out.
// Optional macro VPROC_DIV_EARLY_TERM_EN: finish in one cycle when |dividend| < |divisor|.
module vproc_div_block
  import vproc_div_block_pkg::*;
#(
  parameter int unsigned ELEM_W         = DIV_ELEM_W_DEF,
  parameter int unsigned BITS_PER_CYCLE = DIV_BITS_PER_CYCLE_DEF,
  parameter int unsigned TAG_W          = DIV_TAG_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              signed_i,
  input  logic [ELEM_W-1:0] dividend_i,
  input  logic [ELEM_W-1:0] divisor_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ELEM_W-1:0] quot_o,
  output logic [ELEM_W-1:0] rem_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int unsigned STEPS = div_steps(ELEM_W, BITS_PER_CYCLE);
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ELEM_W:0]     rem_r;
  logic [ELEM_W-1:0]   dvd_r;
  logic [ELEM_W:0]     div_r;
  logic                q_neg;
  logic                r_neg;
  logic [TAG_W-1:0]    tag_r;

  logic                neg_a;
  logic                neg_b;
  logic [ELEM_W-1:0]   abs_a;
  logic [ELEM_W:0]     b_ext;
  logic [ELEM_W:0]     abs_b;
  logic                div_zero;
  logic                ovf;
  logic                early;

  logic                is_busy;
  logic [ELEM_W-1:0]   dvd_cur;
  logic [ELEM_W:0]     div_cur;
  logic [ELEM_W:0]     rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [ELEM_W-1:0]   dvd_next;
  logic [ELEM_W-1:0]   quot_abs;
  logic [ELEM_W-1:0]   rem_abs;

  assign neg_a    = signed_i & dividend_i[ELEM_W-1];
  assign neg_b    = signed_i & divisor_i[ELEM_W-1];
  assign abs_a    = neg_a ? -dividend_i : dividend_i;
  assign b_ext    = {neg_b, divisor_i};
  assign abs_b    = neg_b ? -b_ext : b_ext;
  assign div_zero = (divisor_i == '0);
  assign ovf      = signed_i && (dividend_i == {1'b1, {(ELEM_W-1){1'b0}}}) && (divisor_i == '1);

`ifdef VPROC_DIV_EARLY_TERM_EN
  assign early = !div_zero && ({1'b0, abs_a} < abs_b);
`else
  assign early = 1'b0;
`endif

  // The first step runs in the accept cycle straight from the operands, so the
  // BUSY phase needs one cycle fewer than the step count.
  assign is_busy      = (state == BUSY);
  assign rem_chain[0] = is_busy ? rem_r : '0;
  assign dvd_cur      = is_busy ? dvd_r : abs_a;
  assign div_cur      = is_busy ? div_r : abs_b;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    vproc_div_step #(.ELEM_W(ELEM_W)) u_step (
      .rem_i      (rem_chain[g]),
      .dvd_bit_i  (dvd_cur[ELEM_W-1-g]),
      .divisor_i  (div_cur),
      .rem_o      (rem_chain[g+1]),
      .quot_bit_o (q_bits[BITS_PER_CYCLE-1-g])
    );
  end

  assign dvd_next = {dvd_cur[ELEM_W-BITS_PER_CYCLE-1:0], q_bits};
  assign quot_abs = dvd_next;
  assign rem_abs  = rem_chain[BITS_PER_CYCLE][ELEM_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      div_r       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      tag_r       <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      quot_o      <= '0;
      rem_o       <= '0;
      tag_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            in_ready_o <= 1'b0;
            if (div_zero || ovf || early) begin
              quot_o      <= div_zero ? '1 : (ovf ? dividend_i : '0);
              rem_o       <= ovf ? '0 : dividend_i;
              tag_o       <= tag_i;
              out_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              rem_r <= rem_chain[BITS_PER_CYCLE];
              dvd_r <= dvd_next;
              div_r <= abs_b;
              q_neg <= neg_a ^ neg_b;
              r_neg <= neg_a;
              tag_r <= tag_i;
              cnt   <= CNT_W'(1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_r <= rem_chain[BITS_PER_CYCLE];
          dvd_r <= dvd_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            quot_o      <= q_neg ? -quot_abs : quot_abs;
            rem_o       <= r_neg ? -rem_abs : rem_abs;
            tag_o       <= tag_r;
            out_valid_o <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vproc_div_block.sv
// Scoreboard bench for vproc_div_block: driver pushes expectations, monitor checks outputs.
module tb_vproc_div_block;

  localparam int W = 16;
  localparam int TW = 4;
  localparam int PER = 10;

`ifdef VPROC_DIV_EARLY_TERM_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          sgn = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [TW-1:0] tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  quot;
  logic [W-1:0]  rem;
  logic [TW-1:0] tag_out;

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] t;
    int            lat;
    time           t_acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  time  acc_time;
  time  prev_acc;

  always #(PER/2) clk = ~clk;

  vproc_div_block dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .signed_i    (sgn),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .quot_o      (quot),
    .rem_o       (rem),
    .tag_o       (tag_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Issues one request starting at a negedge; returns at the negedge after the accept edge.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input int lat, input bit push);
    bit   done;
    exp_t e;
    done = 0;
    in_valid = 1'b1;
    sgn = s;
    dividend = a;
    divisor = b;
    tag = t;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        acc_time = $time;
        if (push) begin
          e.q = eq; e.r = er; e.t = t; e.lat = lat; e.t_acc = acc_time;
          sb.push_back(e);
        end
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: request a=0x%0h b=0x%0h never accepted", a, b);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: samples just after the falling edge, compares against the queue head.
  initial begin
    bit   prev_v;
    bit   chk_rel;
    exp_t e;
    int   lat;
    prev_v = 0;
    chk_rel = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_v = 0;
        chk_rel = 0;
      end else begin
        if (chk_rel) begin
          chk("release_valid", {31'b0, out_valid}, 32'd0);
          chk("release_ready", {31'b0, in_ready}, 32'd1);
          chk_rel = 0;
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: quot=0x%0h rem=0x%0h with empty scoreboard", quot, rem);
          end else begin
            e = sb[0];
            if (!prev_v) begin
              lat = int'(($time - e.t_acc + 4) / PER);
              chk("latency", lat, e.lat);
            end
            chk("quot", {16'b0, quot}, {16'b0, e.q});
            chk("rem", {16'b0, rem}, {16'b0, e.r});
            chk("tag", {28'b0, tag_out}, {28'b0, e.t});
            chk("ready_in_done", {31'b0, in_ready}, 32'd0);
            if (out_ready) begin
              void'(sb.pop_front());
              chk_rel = 1;
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    int n;
    #(3*PER + 2);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_quot", {16'b0, quot}, 32'd0);
    chk("rst_rem", {16'b0, rem}, 32'd0);
    chk("rst_tag", {28'b0, tag_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic division, signed variants, and special cases.
    do_op(0, 16'd100,  16'd7,    4'd3, 16'd14,   16'd2,    16, 1);
    do_op(1, 16'hFFF9, 16'h0002, 4'd4, 16'hFFFD, 16'hFFFF, 16, 1);
    do_op(1, 16'h0007, 16'hFFFE, 4'd5, 16'hFFFD, 16'h0001, 16, 1);
    do_op(1, 16'hFF9C, 16'hFFF9, 4'd6, 16'd14,   16'hFFFE, 16, 1);
    do_op(1, 16'h8000, 16'h0002, 4'd7, 16'hC000, 16'h0000, 16, 1);
    do_op(1, 16'h1234, 16'h0000, 4'd8, 16'hFFFF, 16'h1234, 1,  1);
    do_op(0, 16'h0000, 16'h0000, 4'd9, 16'hFFFF, 16'h0000, 1,  1);
    do_op(1, 16'h8000, 16'hFFFF, 4'hA, 16'h8000, 16'h0000, 1,  1);
    do_op(0, 16'h8000, 16'hFFFF, 4'hB, 16'h0000, 16'h8000, LAT_SMALL, 1);
    do_op(0, 16'd5,    16'd9,    4'hC, 16'h0000, 16'd5,    LAT_SMALL, 1);
    do_op(1, 16'hFFFB, 16'd9,    4'hD, 16'h0000, 16'hFFFB, LAT_SMALL, 1);
    do_op(0, 16'hFFFF, 16'h0100, 4'hE, 16'h00FF, 16'h00FF, 16, 1);
    wait_drain(100);

    // Backpressure: hold the result for five cycles.
    out_ready = 1'b0;
    do_op(0, 16'd200, 16'd9, 4'h1, 16'd22, 16'd2, 16, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      $display("FAIL bp_timeout: out_valid=%0b expected 1", out_valid);
    end
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    wait_drain(20);

    // Back-to-back throughput with the consumer always ready.
    do_op(0, 16'd200, 16'd9, 4'h2, 16'd22, 16'd2, 16, 1);
    prev_acc = acc_time;
    do_op(0, 16'hFFFF, 16'h0100, 4'h3, 16'h00FF, 16'h00FF, 16, 1);
    chk("period_1", int'((acc_time - prev_acc) / PER), 32'd17);
    prev_acc = acc_time;
    do_op(1, 16'h8000, 16'h0002, 4'h4, 16'hC000, 16'h0000, 16, 1);
    chk("period_2", int'((acc_time - prev_acc) / PER), 32'd17);
    wait_drain(100);

    // Asynchronous reset in the middle of BUSY discards the operation.
    do_op(0, 16'd777, 16'd5, 4'h5, 16'd0, 16'd0, 16, 0);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_quot", {16'b0, quot}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, 16'd1000, 16'd10, 4'h6, 16'd100, 16'd0, 16, 1);
    wait_drain(100);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
